// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX byte channel among num_req_p requesters.
// Define UART_TX_ARB_HEADER_EN to prefix every packet with the granted requester index.
module uart_tx_arbiter #(
    parameter int num_req_p   = 4,
    parameter int data_bits_p = 8,
    parameter int timeout_p   = 1024
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_req_p-1:0]               req_v_i,
    input  logic [num_req_p*data_bits_p-1:0]   req_data_i,
    input  logic [num_req_p-1:0]               req_last_i,
    output logic [num_req_p-1:0]               req_ready_and_o,
    output logic                               tx_v_o,
    output logic [data_bits_p-1:0]             tx_o,
    input  logic                               tx_ready_and_i,
    output logic                               grant_v_o,
    output logic [$clog2(num_req_p)-1:0]       grant_id_o,
    output logic                               timeout_o
);

    // state | meaning
    // idle  | no owner; arbitrate among pending requesters
    // hdr   | owner chosen; sending its index byte (header build only)
    // busy  | owner's bytes pass straight through to the UART
    localparam int id_w  = $clog2(num_req_p);
    localparam int cnt_w = $clog2(timeout_p + 1);
    localparam logic [id_w:0]      num_req_c    = (id_w + 1)'(num_req_p);
    localparam logic [id_w-1:0]    last_id_c    = id_w'(num_req_p - 1);
    localparam logic [cnt_w-1:0]   timeout_last = cnt_w'(timeout_p - 1);

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_busy = 2'd1
`ifdef UART_TX_ARB_HEADER_EN
        , st_hdr = 2'd2
`endif
    } state_t;

    state_t                 state;
    logic [id_w-1:0]        rr;
    logic [cnt_w-1:0]       idle_cnt;

    logic                   pick_v;
    logic [id_w-1:0]        pick;
    logic [id_w:0]          sum;
    logic                   sel_v;
    logic                   sel_last;
    logic [data_bits_p-1:0] sel_data;
    logic [num_req_p-1:0]   grant_mask;
    logic [data_bits_p-1:0] hdr_byte;
    logic [id_w-1:0]        next_rr;

    // Scan downward so the smallest offset from rr is the one that sticks.
    always_comb begin
        pick_v = 1'b0;
        pick   = '0;
        sum    = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            sum = {1'b0, rr} + (id_w + 1)'(i);
            if (sum >= num_req_c) sum = sum - num_req_c;
            if (req_v_i[sum[id_w-1:0]]) begin
                pick_v = 1'b1;
                pick   = sum[id_w-1:0];
            end
        end
    end

    always_comb begin
        sel_v      = 1'b0;
        sel_last   = 1'b0;
        sel_data   = '0;
        grant_mask = '0;
        for (int k = 0; k < num_req_p; k++) begin
            if (grant_id_o == id_w'(k)) begin
                sel_v         = req_v_i[k];
                sel_last      = req_last_i[k];
                sel_data      = req_data_i[k*data_bits_p +: data_bits_p];
                grant_mask[k] = 1'b1;
            end
        end
    end

    always_comb begin
        hdr_byte             = '0;
        hdr_byte[id_w-1:0]   = grant_id_o;
    end

    // Explicit wrap keeps non-power-of-two requester counts in range.
    assign next_rr = (grant_id_o == last_id_c) ? '0 : grant_id_o + 1'b1;

    always_comb begin
        tx_v_o          = 1'b0;
        tx_o            = '0;
        req_ready_and_o = '0;
        if (reset_n_i) begin
            case (state)
                st_busy: begin
                    tx_v_o          = sel_v;
                    tx_o            = sel_data;
                    req_ready_and_o = grant_mask & {num_req_p{tx_ready_and_i}};
                end
`ifdef UART_TX_ARB_HEADER_EN
                st_hdr: begin
                    tx_v_o = 1'b1;
                    tx_o   = hdr_byte;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state      <= st_idle;
            rr         <= '0;
            grant_id_o <= '0;
            grant_v_o  <= 1'b0;
            timeout_o  <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                st_idle: begin
                    if (pick_v) begin
                        grant_id_o <= pick;
                        grant_v_o  <= 1'b1;
                        idle_cnt   <= '0;
`ifdef UART_TX_ARB_HEADER_EN
                        state      <= st_hdr;
`else
                        state      <= st_busy;
`endif
                    end
                end
`ifdef UART_TX_ARB_HEADER_EN
                st_hdr: begin
                    if (tx_ready_and_i) begin
                        state    <= st_busy;
                        idle_cnt <= '0;
                    end
                end
`endif
                st_busy: begin
                    if (sel_v && tx_ready_and_i) begin
                        idle_cnt <= '0;
                        if (sel_last) begin
                            state     <= st_idle;
                            grant_v_o <= 1'b0;
                            rr        <= next_rr;
                        end
                    end else if (!sel_v) begin
                        // A stalled UART with valid data never counts as requester idleness.
                        if (idle_cnt >= timeout_last) begin
                            state     <= st_idle;
                            grant_v_o <= 1'b0;
                            rr        <= next_rr;
                            timeout_o <= 1'b1;
                            idle_cnt  <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a randomized packet mix, checked against
// a packet-level round-robin model; builds with or without UART_TX_ARB_HEADER_EN.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int TO = 8;

    typedef logic [8:0] q9_t[$];

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_v;
    logic [N*D-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready_and_o;
    logic           tx_v_o;
    logic [D-1:0]   tx_o;
    logic           tx_ready;
    logic           grant_v_o;
    logic [1:0]     grant_id_o;
    logic           timeout_o;

    logic [2:0]     req_v3;
    logic [23:0]    req_data3;
    logic [2:0]     req_last3;
    logic [2:0]     ready3;
    logic           tx_v3;
    logic [7:0]     tx3;
    logic           tx_ready3;
    logic           grant_v3;
    logic [1:0]     grant_id3;
    logic           timeout3;

    int             n_cmp = 0;
    int             n_fail = 0;
    int             m_rr = 0;
    int             exp_pkts;
    int             tx_pct;
    bit             gaps_en;
    q9_t            src_q[N];
    int             gap[N];
    logic [10:0]    exp_q[$];

    int             h, to_cnt, to_cyc, rdy_seen;
    bit             got, ok;
    bit             hs1;
    logic [1:0]     got_id;
    logic [7:0]     got_b;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.num_req_p(N), .data_bits_p(D), .timeout_p(TO)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_data_i(req_data),
        .req_last_i(req_last), .req_ready_and_o(req_ready_and_o), .tx_v_o(tx_v_o),
        .tx_o(tx_o), .tx_ready_and_i(tx_ready), .grant_v_o(grant_v_o),
        .grant_id_o(grant_id_o), .timeout_o(timeout_o)
    );

    uart_tx_arbiter #(.num_req_p(3), .data_bits_p(8), .timeout_p(1024)) dut3 (
        .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v3), .req_data_i(req_data3),
        .req_last_i(req_last3), .req_ready_and_o(ready3), .tx_v_o(tx_v3),
        .tx_o(tx3), .tx_ready_and_i(tx_ready3), .grant_v_o(grant_v3),
        .grant_id_o(grant_id3), .timeout_o(timeout3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input bit l);
        src_q[r].push_back({l, d});
    endtask

    // Packet order from the round-robin rule, assuming every requester with work is waiting.
    function automatic void build_expected();
        int cnt[N];
        int pos[N];
        int r;
        logic [8:0] b;
        exp_pkts = 0;
        for (int k = 0; k < N; k++) begin
            cnt[k] = 0;
            pos[k] = 0;
            for (int j = 0; j < src_q[k].size(); j++)
                if (src_q[k][j][8]) cnt[k]++;
        end
        for (int p = 0; p < 64; p++) begin
            r = -1;
            for (int i = 0; i < N; i++)
                if (r < 0 && cnt[(m_rr + i) % N] > 0) r = (m_rr + i) % N;
            if (r < 0) break;
`ifdef UART_TX_ARB_HEADER_EN
            exp_q.push_back({1'b0, r[1:0], 8'(r)});
`endif
            b = '0;
            while (!b[8]) begin
                b = src_q[r][pos[r]];
                pos[r]++;
                exp_q.push_back({b[8], r[1:0], b[7:0]});
            end
            cnt[r]--;
            m_rr = (r + 1) % N;
            exp_pkts++;
        end
    endfunction

    task automatic drive_update();
        for (int r = 0; r < N; r++) begin
            if (src_q[r].size() > 0 && gap[r] == 0) begin
                req_v[r]          = 1'b1;
                req_data[r*D +: D] = src_q[r][0][7:0];
                req_last[r]       = src_q[r][0][8];
            end else begin
                req_v[r]    = 1'b0;
                req_last[r] = 1'b0;
            end
        end
        tx_ready = (tx_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < tx_pct);
    endtask

    task automatic run_engine(input int max_cyc, input bit chk_span);
        int ncyc, first, last_x, nx;
        bit gv_drop;
        logic [10:0] e;
        logic [N-1:0] hs;
        logic [8:0] popped;
        build_expected();
        nx = exp_q.size();
        first = -1; last_x = -1; gv_drop = 0; ncyc = 0;
        for (int r = 0; r < N; r++) gap[r] = 0;
        @(posedge clk); #1;
        drive_update();
        while (exp_q.size() > 0 && ncyc < max_cyc) begin
            @(negedge clk);
            if (gv_drop) begin
                chk("grant_v_drop", grant_v_o, 0);
                gv_drop = 0;
            end
            chk("no_timeout", timeout_o, 0);
            chk("ready_onehot0", ($countones(req_ready_and_o) <= 1), 1);
            hs = req_v & req_ready_and_o;
            if (tx_v_o && tx_ready) begin
                e = exp_q.pop_front();
                chk("tx_byte", tx_o, e[7:0]);
                chk("grant_id", grant_id_o, e[9:8]);
                chk("grant_v", grant_v_o, 1);
                gv_drop = e[10];
                if (first < 0) first = ncyc;
                last_x = ncyc;
            end
            @(posedge clk); #1;
            for (int r = 0; r < N; r++) begin
                if (hs[r]) begin
                    popped = src_q[r].pop_front();
                    if (gaps_en && !popped[8]) gap[r] = $urandom_range(0, 3);
                end else if (gap[r] > 0) begin
                    gap[r]--;
                end
            end
            drive_update();
            ncyc++;
        end
        @(negedge clk);
        if (gv_drop) chk("grant_v_drop", grant_v_o, 0);
        chk("drain", exp_q.size(), 0);
        if (chk_span) begin
            chk("first_latency", first, 1);
            chk("packet_span", last_x - first, nx - 1 + exp_pkts - 1);
        end
        exp_q.delete();
        for (int r = 0; r < N; r++) src_q[r].delete();
        req_v = '0;
        req_last = '0;
    endtask

    task automatic xfer3(output logic [1:0] id, output logic [7:0] b, output bit done);
        logic [2:0] hs3;
        done = 0; id = '0; b = '0;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            hs3 = req_v3 & ready3;
            if (|hs3) begin
                done = 1; id = grant_id3; b = tx3;
            end
            @(posedge clk); #1;
            req_v3 = req_v3 & ~hs3;
        end
    endtask

    initial begin
        reset_n = 1'b0; req_v = '0; req_data = '0; req_last = '0; tx_ready = 1'b0;
        req_v3 = '0; req_data3 = {8'hA2, 8'hA1, 8'hA0}; req_last3 = 3'b111; tx_ready3 = 1'b1;
        tx_pct = 100; gaps_en = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_v", tx_v_o, 0);
        chk("rst_tx", tx_o, 0);
        chk("rst_ready", req_ready_and_o, 0);
        chk("rst_grant_v", grant_v_o, 0);
        chk("rst_grant_id", grant_id_o, 0);
        chk("rst_timeout", timeout_o, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Three-requester wrap: 1 -> 2 -> 0.
        req_v3 = 3'b010;
        xfer3(got_id, got_b, ok);
        chk("n3_first_ok", ok, 1); chk("n3_first_id", got_id, 1); chk("n3_first_b", got_b, 8'hA1);
        req_v3 = req_v3 | 3'b101;
        xfer3(got_id, got_b, ok);
        chk("n3_second_id", got_id, 2); chk("n3_second_b", got_b, 8'hA2);
        xfer3(got_id, got_b, ok);
        chk("n3_wrap_id", got_id, 0); chk("n3_wrap_b", got_b, 8'hA0);
        @(negedge clk);
        chk("n3_grant_v_end", grant_v3, 0);
        chk("n3_timeout", timeout3, 0);

        // Requester 1, three bytes.
        push(1, 8'h41, 0); push(1, 8'h42, 0); push(1, 8'h43, 1);
        run_engine(100, 1);

        // Requesters 0 and 2, two 2-byte packets each.
        push(0, 8'h01, 0); push(0, 8'h02, 1); push(0, 8'h03, 0); push(0, 8'h04, 1);
        push(2, 8'h21, 0); push(2, 8'h22, 1); push(2, 8'h23, 0); push(2, 8'h24, 1);
        run_engine(100, 1);

        // Requester 3 finishes while 0 waits.
        push(3, 8'h31, 0); push(3, 8'h32, 1); push(0, 8'h35, 1);
        run_engine(100, 1);

        // Timeout: requester 1 abandons its packet, requester 2 waits.
        @(posedge clk); #1;
        req_v = 4'b0110; req_data = {8'h00, 8'h22, 8'h11, 8'h00}; req_last = 4'b0100; tx_ready = 1'b1;
        h = -1; to_cnt = 0; to_cyc = -1; got = 0; got_id = '0; got_b = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (timeout_o) begin to_cnt++; to_cyc = c; end
            hs1 = req_v[1] & req_ready_and_o[1];
            if (hs1) begin
                chk("to_first_id", grant_id_o, 1);
                chk("to_first_b", tx_o, 8'h11);
                h = c;
            end
            if (!got && req_v[2] && req_ready_and_o[2]) begin
                got = 1; got_id = grant_id_o; got_b = tx_o;
            end
            @(posedge clk); #1;
            if (hs1) req_v[1] = 1'b0;
            if (got) req_v[2] = 1'b0;
        end
        chk("to_pulses", to_cnt, 1);
        chk("to_cycle", to_cyc, h + TO + 1);
        chk("to_next_ok", got, 1);
        chk("to_next_id", got_id, 2);
        chk("to_next_b", got_b, 8'h22);
        req_last = '0;
        m_rr = 3;

        // Long UART stall must not revoke the grant.
        req_v = 4'b0001; req_data = {24'h0, 8'h5A}; req_last = 4'b0001; tx_ready = 1'b0;
        to_cnt = 0; rdy_seen = 0;
        repeat (2000) begin
            @(negedge clk);
            if (timeout_o) to_cnt++;
            if (|req_ready_and_o) rdy_seen++;
        end
        chk("stall_timeout", to_cnt, 0);
        chk("stall_ready", rdy_seen, 0);
        chk("stall_grant_v", grant_v_o, 1);
        chk("stall_tx_v", tx_v_o, 1);
        @(posedge clk); #1;
        tx_ready = 1'b1; got = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (!got && req_v[0] && req_ready_and_o[0]) begin
                got = 1;
                chk("stall_byte", tx_o, 8'h5A);
                chk("stall_id", grant_id_o, 0);
            end
            @(posedge clk); #1;
            if (got) req_v[0] = 1'b0;
        end
        chk("stall_done", got, 1);
        req_last = '0;
        m_rr = 1;

        // Single-byte packet from requester 2 (header precedes it when enabled).
        push(2, 8'h55, 1);
        run_engine(100, 1);

        // Randomized mix with mid-packet gaps and UART backpressure.
        gaps_en = 1; tx_pct = 70;
        for (int r = 0; r < N; r++) begin
            int npk;
            npk = (r == 0) ? $urandom_range(1, 2) : $urandom_range(0, 2);
            for (int p = 0; p < npk; p++) begin
                int len;
                len = $urandom_range(1, 4);
                for (int j = 0; j < len; j++) push(r, 8'($urandom), (j == len - 1));
            end
        end
        run_engine(3000, 0);
        gaps_en = 0; tx_pct = 100;

        // Reset mid-packet.
        @(posedge clk); #1;
        req_v = 4'b0010; req_data = {16'h0, 8'h71, 8'h00}; req_last = 4'b0000; tx_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            if (req_v[1] && req_ready_and_o[1]) got = 1;
            @(posedge clk); #1;
        end
        chk("rstmid_started", got, 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rstmid_tx_v_low", tx_v_o, 0);
        chk("rstmid_ready_low", req_ready_and_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_tx_v", tx_v_o, 0);
        chk("rstmid_tx", tx_o, 0);
        chk("rstmid_grant_v", grant_v_o, 0);
        chk("rstmid_grant_id", grant_id_o, 0);
        chk("rstmid_timeout", timeout_o, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        req_v = 4'b1010; req_data = {8'h73, 8'h00, 8'h72, 8'h00}; req_last = 4'b1010;
        got = 0; got_id = '0; got_b = '0;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            if (|(req_v & req_ready_and_o)) begin
                got = 1; got_id = grant_id_o; got_b = tx_o;
            end
            @(posedge clk); #1;
        end
        chk("rstmid_rr_id", got_id, 1);
        chk("rstmid_rr_b", got_b, 8'h72);
        req_v = '0;
        req_last = '0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
